// File: rtl/calc_core_sequencer.sv
// Command sequencer feeding the calculation core: fetches instructions from a
// synchronous program memory, issues EXEC commands, runs one hardware loop.
module calc_core_sequencer #(
    parameter int unsigned                    PC_W           = 10,
    parameter int unsigned                    CMD_SIZE       = 32,
    parameter int unsigned                    INPUTMODE_SIZE = 2,
    parameter logic [INPUTMODE_SIZE-1:0]      MODE_IDLE      = 2'd0,
    parameter logic [INPUTMODE_SIZE-1:0]      MODE_EXEC      = 2'd2,
    parameter int unsigned                    TIMEOUT        = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [PC_W-1:0]           start_pc,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [PC_W-1:0]           err_pc,
    output logic                      prog_rd,
    output logic [PC_W-1:0]           prog_addr,
    input  logic [CMD_SIZE+1:0]       prog_data,
    output logic [INPUTMODE_SIZE-1:0] core_mode,
    output logic [CMD_SIZE-1:0]       core_cmd,
    input  logic                      core_finished,
    output logic [15:0]               exec_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_GAP, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_EXEC, OP_LSET, OP_LOOP, OP_HALT
    } op_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc;
    logic [15:0]         loop_cnt;
    logic [TMR_W-1:0]    timer;
    op_t                 op;
    logic [CMD_SIZE-1:0] payload;
    logic                pc_last;
    logic                fin_ok;
    logic                tmo;

    assign op      = op_t'(prog_data[CMD_SIZE+1:CMD_SIZE]);
    assign payload = prog_data[CMD_SIZE-1:0];
    assign pc_last = (pc == '1);
    // finished is only trusted from the second WAIT cycle (timer already advanced)
    assign fin_ok  = core_finished && (timer != '0);
    assign tmo     = (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_EXEC: state_d = S_WAIT;
                    OP_LSET: state_d = pc_last ? S_ERR : S_FETCH;
                    OP_LOOP: state_d = ((loop_cnt != '0) || !pc_last) ? S_FETCH : S_ERR;
                    OP_HALT: state_d = S_DONE;
                endcase
            end
            S_WAIT: begin
                if (fin_ok)   state_d = pc_last ? S_ERR : S_GAP;
                else if (tmo) state_d = S_ERR;
            end
            S_GAP:    state_d = S_FETCH;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prog_rd   = (state_q == S_FETCH);
        prog_addr = pc;
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            err        <= 1'b0;
            err_pc     <= '0;
            core_cmd   <= '0;
            core_mode  <= MODE_IDLE;
            exec_count <= '0;
            pc         <= '0;
            loop_cnt   <= '0;
            timer      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc         <= start_pc;
                        exec_count <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_DECODE: begin
                    unique case (op)
                        OP_EXEC: begin
                            core_cmd  <= payload;
                            core_mode <= MODE_EXEC;
                            timer     <= '0;
                        end
                        OP_LSET: begin
                            loop_cnt <= payload[15:0];
                            if (!pc_last) pc <= pc + PC_W'(1);
                        end
                        OP_LOOP: begin
                            if (loop_cnt != '0) begin
                                loop_cnt <= loop_cnt - 16'd1;
                                pc       <= payload[PC_W-1:0];
                            end else if (!pc_last) begin
                                pc <= pc + PC_W'(1);
                            end
                        end
                        OP_HALT: ;
                    endcase
                end
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (fin_ok) begin
                        core_mode <= MODE_IDLE;
                        if (exec_count != '1) exec_count <= exec_count + 16'd1;
                        // pc stays put at the top address so ERR reports it
                        if (!pc_last) pc <= pc + PC_W'(1);
                    end
                end
                S_DONE: busy <= 1'b0;
                S_ERR: begin
                    err       <= 1'b1;
                    err_pc    <= pc;
                    busy      <= 1'b0;
                    core_mode <= MODE_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core_sequencer.sv
// Randomized self-checking bench for calc_core_sequencer against a program
// interpreter model with a reactive core and synchronous program memory.
module tb_calc_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic        busy, done, err, prog_rd;
    logic [9:0]  err_pc, prog_addr;
    logic [33:0] prog_data = '0;
    logic [1:0]  core_mode;
    logic [31:0] core_cmd;
    logic        core_finished = 1'b0;
    logic [15:0] exec_count;

    always #5 clk = ~clk;

    calc_core_sequencer #(
        .PC_W(10), .CMD_SIZE(32), .INPUTMODE_SIZE(2),
        .MODE_IDLE(2'd0), .MODE_EXEC(2'd2), .TIMEOUT(4095)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .busy(busy), .done(done), .err(err), .err_pc(err_pc),
        .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
        .core_mode(core_mode), .core_cmd(core_cmd),
        .core_finished(core_finished), .exec_count(exec_count)
    );

    // program memory: data valid the cycle after the read
    logic [33:0] mem [0:1023];
    always @(posedge clk) if (prog_rd) prog_data <= mem[prog_addr];

    // core model: finished on its fin_n_cfg-th EXEC cycle, or held high, or never (0)
    bit fin_hold = 1'b0;
    int fin_n_cfg = 0;
    int exec_cyc = 0;
    always @(negedge clk) begin
        if (core_mode == 2'd2) exec_cyc++;
        else exec_cyc = 0;
        core_finished = fin_hold || ((fin_n_cfg != 0) && (exec_cyc >= fin_n_cfg));
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] w_exec(input logic [31:0] p); return {2'b00, p}; endfunction
    function automatic logic [33:0] w_lset(input logic [31:0] p); return {2'b01, p}; endfunction
    function automatic logic [33:0] w_loop(input logic [31:0] p); return {2'b10, p}; endfunction
    function automatic logic [33:0] w_halt();                      return {2'b11, 32'h0}; endfunction

    // observed activity, cycle 1 = first cycle after start is accepted
    bit          mon_en = 1'b0;
    int          mon_cyc = 0;
    logic [1:0]  prev_mode = 2'd0;
    logic [31:0] d_cmds[$];
    int          d_entry[$];
    int          d_done_cnt = 0;
    int          d_done_cyc = -1;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            if (core_mode == 2'd2 && prev_mode != 2'd2) begin
                d_cmds.push_back(core_cmd);
                d_entry.push_back(mon_cyc);
            end
            if (done) begin
                d_done_cnt++;
                d_done_cyc = mon_cyc;
            end
        end
        prev_mode = core_mode;
    end

    // reference: interpret the program, accumulating per-instruction cycle costs
    logic [31:0] m_cmds[$];
    int          m_entry[$];
    int          m_done_cyc;
    logic [15:0] m_count;
    bit          m_err;
    logic [9:0]  m_errpc;
    logic [15:0] m_lc = '0;

    task automatic model_run(input logic [9:0] spc, input int wait_len);
        int pc, cyc;
        logic [33:0] w;
        pc = spc; cyc = 0;
        m_cmds.delete(); m_entry.delete();
        m_count = '0; m_err = 1'b0; m_errpc = '0; m_done_cyc = -1;
        for (int step = 0; step < 20000; step++) begin
            w = mem[pc];
            case (w[33:32])
                2'b00: begin
                    m_cmds.push_back(w[31:0]);
                    m_entry.push_back(cyc + 3);
                    if (wait_len == 0) begin m_err = 1'b1; m_errpc = 10'(pc); return; end
                    cyc += 3 + wait_len;
                    if (m_count != 16'hFFFF) m_count++;
                    if (pc == 1023) begin m_err = 1'b1; m_errpc = 10'(pc); return; end
                    pc++;
                end
                2'b01: begin
                    m_lc = w[15:0];
                    cyc += 2;
                    if (pc == 1023) begin m_err = 1'b1; m_errpc = 10'(pc); return; end
                    pc++;
                end
                2'b10: begin
                    cyc += 2;
                    if (m_lc != 0) begin
                        m_lc--;
                        pc = int'(w[9:0]);
                    end else begin
                        if (pc == 1023) begin m_err = 1'b1; m_errpc = 10'(pc); return; end
                        pc++;
                    end
                end
                default: begin m_done_cyc = cyc + 3; return; end
            endcase
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_lc = '0;
    endtask

    task automatic run_prog(input logic [9:0] spc, input bit hold, input int fin_n,
                            input bit hammer, input int glitch_at, input int bound);
        int t;
        fin_hold = hold;
        fin_n_cfg = fin_n;
        model_run(spc, hold ? 2 : fin_n);
        @(negedge clk); start = 1'b1; start_pc = spc;
        @(posedge clk);
        mon_cyc = 0; d_cmds.delete(); d_entry.delete();
        d_done_cnt = 0; d_done_cyc = -1; mon_en = 1'b1;
        #1 start = 1'b0;
        t = 0;
        while (t < bound) begin
            @(negedge clk); t++;
            if (t == 1) begin
                check_eq("busy_after_start", busy, 1);
                check_eq("err_cleared", err, 0);
            end
            if (!busy) begin start = 1'b0; break; end
            // starts while busy (including the DONE/ERR cycle) must be ignored
            start = hammer || (t == glitch_at) || (done === 1'b1);
            start_pc = 10'($urandom_range(0, 1023));
        end
        start = 1'b0;
        if (busy) begin
            check_eq("run_bound", busy, 0);
            pulse_reset();
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check_eq("n_cmds", d_cmds.size(), m_cmds.size());
        for (int i = 0; i < m_cmds.size() && i < d_cmds.size(); i++) begin
            check_eq($sformatf("cmd[%0d]", i), d_cmds[i], m_cmds[i]);
            check_eq($sformatf("entry_cyc[%0d]", i), d_entry[i], m_entry[i]);
        end
        check_eq("exec_count", exec_count, m_count);
        check_eq("err", err, m_err);
        if (m_err) check_eq("err_pc", err_pc, m_errpc);
        check_eq("done_pulses", d_done_cnt, m_err ? 0 : 1);
        if (!m_err) check_eq("done_cyc", d_done_cyc, m_done_cyc);
        check_eq("busy_end", busy, 0);
        check_eq("mode_end", core_mode, 0);
        check_eq("prog_rd_end", prog_rd, 0);
        if (m_cmds.size() > 0) check_eq("cmd_held", core_cmd, m_cmds[m_cmds.size()-1]);
    endtask

    initial begin
        logic [9:0]  spc;
        logic [31:0] rnd;
        int a, first, k;
        rst = 1'b1; start = 1'b0; start_pc = '0;
        for (int i = 0; i < 1024; i++) mem[i] = w_halt();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_pc", err_pc, 0);
        check_eq("rst_prog_rd", prog_rd, 0);
        check_eq("rst_prog_addr", prog_addr, 0);
        check_eq("rst_mode", core_mode, 0);
        check_eq("rst_cmd", core_cmd, 0);
        check_eq("rst_count", exec_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single EXEC then HALT, core finishes on its 3rd cycle
        mem[10'h010] = w_exec(32'h0A010203);
        mem[10'h011] = w_halt();
        run_prog(10'h010, 1'b0, 3, 1'b0, 0, 3000);

        // loop: LSET 3 gives four passes
        mem[0] = w_lset(32'd3);
        mem[1] = w_exec(32'h0C0C0C0C);
        mem[2] = w_loop(32'h001);
        mem[3] = w_halt();
        run_prog(10'h000, 1'b0, 3, 1'b0, 0, 3000);

        // finished held high: 5-cycle spacing between EXEC entries
        mem[10'h040] = w_exec(32'h11111111);
        mem[10'h041] = w_exec(32'h22222222);
        mem[10'h042] = w_exec(32'h33333333);
        mem[10'h043] = w_halt();
        run_prog(10'h040, 1'b1, 0, 1'b0, 0, 3000);

        // core never finishes: timeout, with start hammered throughout
        mem[10'h080] = w_exec(32'hBEEF0080);
        run_prog(10'h080, 1'b0, 0, 1'b1, 0, 6000);

        // EXEC at top address: pc overflow after completion; start clears err
        mem[10'h3FF] = w_exec(32'hDEAD0001);
        run_prog(10'h3FF, 1'b0, 2, 1'b0, 0, 3000);

        // asynchronous reset in the middle of WAIT
        mem[10'h100] = w_exec(32'h55AA55AA);
        fin_hold = 1'b0; fin_n_cfg = 0;
        @(negedge clk); start = 1'b1; start_pc = 10'h100;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mid_wait_mode", core_mode, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_mode", core_mode, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_cmd", core_cmd, 0);
        check_eq("arst_err_pc", err_pc, 0);
        check_eq("arst_prog_addr", prog_addr, 0);
        @(negedge clk); rst = 1'b0;
        m_lc = '0;

        for (int r = 0; r < 20; r++) begin
            spc = 10'($urandom_range(0, 1000));
            a = int'(spc);
            if ($urandom_range(0, 3) != 0) begin
                rnd = $urandom;
                mem[a] = w_lset({rnd[31:16], 16'($urandom_range(0, 3))});
                a++;
            end
            first = a;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin mem[a] = w_exec($urandom); a++; end
            rnd = $urandom;
            mem[a] = w_loop({rnd[31:10], 10'(first)}); a++;
            if ($urandom_range(0, 1) == 1) begin mem[a] = w_exec($urandom); a++; end
            mem[a] = w_halt();
            run_prog(spc, $urandom_range(0, 3) == 0, $urandom_range(2, 5),
                     $urandom_range(0, 2) == 0, $urandom_range(1, 20), 3000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
